channel_wave_generator: RTL and testbench
=========================================

# channel_wave_generator

Downstream stage of a channel note sequencer. It turns the sequencer's 32-bit phase increment and 8-bit amplitude top into a stream of 8-bit PWM compare samples. On every sample-rate tick it advances a 32-bit phase accumulator and maps the phase to the selected waveform. It scales the result by the current top and presents one sample per tick to the PWM comparator.

## Interface
Parameters:
- none

Ports (name, direction, width, meaning):
- i_clk  in  1  system clock; all logic on rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_tick_stb  in  1  one-cycle sample-rate strobe; each pulse produces exactly one sample
- i_phase_delta  in  32  phase increment per tick from the sequencer; 0 = rest
- i_top  in  8  amplitude top value from the sequencer
- i_top_valid  in  1  i_top is valid; qualifies latching of i_top
- i_wave_sel  in  2  waveform select: 0 square, 1 pulse-25%, 2 sawtooth, 3 triangle
- o_sample  out  8  scaled waveform sample (PWM compare value)
- o_sample_valid  out  1  one-cycle strobe; o_sample updated this cycle

## Operation
- Registers:
  - r_phase[31:0], reset 0.
  - r_prev_delta[31:0], reset 0.
  - r_top[7:0], reset 8'hFF.
  - Stage-1 valid, reset 0.
  - o_sample, reset 0.
  - o_sample_valid, reset 0.
- Stage 1, on a cycle with i_tick_stb=1:
  - Rest: if i_phase_delta==0, r_phase <= 0 and a rest flag is set.
  - Hard sync: else if i_phase_delta != r_prev_delta, r_phase <= i_phase_delta. This is equivalent to resetting the phase to 0 and then accumulating, so every new note starts at phase 0.
  - Otherwise r_phase <= r_phase + i_phase_delta, mod 2^32. Wrap-around is silent.
  - r_prev_delta <= i_phase_delta.
  - i_wave_sel is captured alongside.
  - r_top <= i_top only if i_top_valid=1. If i_top_valid=0, the previous r_top is held.
- Stage 2, on the cycle after a stage-1 tick, with h = r_phase[31:24]:
  - raw value by waveform:
    - square: 8'hFF if h[7] else 8'h00
    - pulse-25%: 8'hFF if h<8'h40 else 8'h00
    - sawtooth: h
    - triangle: {h[6:0],1'b0} if h[7]=0, else ~{h[6:0],1'b0}
  - Rest flag set: raw forced to 0 for every waveform.
  - Scaling: o_sample <= (raw * (r_top + 1)) >> 8.
    - The product is 17 bits wide; take bits [15:8]. This is exact because raw ≤ 255 and top+1 ≤ 256.
    - raw=FF with top=FF gives FF; raw=0 gives 0.
  - o_sample_valid <= 1 for exactly one cycle.
- o_sample holds its value between strobes.
- Inputs are ignored on cycles without i_tick_stb.

## Timing
- Latency: tick in cycle N -> o_sample_valid=1 and new o_sample in cycle N+2.
- Throughput: one tick per cycle is supported. Back-to-back ticks yield back-to-back valid strobes; no stall and no backpressure.
- r_top, r_prev_delta and the wave selection are all captured in the same cycle as the tick they apply to.
- Reset asserted mid-pipeline: all registers return to their reset values immediately; an in-flight sample is discarded and no valid strobe is issued.
- The first tick after reset with a nonzero delta is always a hard sync, because r_prev_delta=0.

## Configuration
- CHANNEL_WAVE_TRIANGLE_EN
  - Defined: i_wave_sel=3 produces the triangle waveform.
  - Undefined: the triangle logic is not compiled, and i_wave_sel=3 behaves as square (sel 0).

## Test plan
- Reset then sawtooth:
  - Stimulus: delta=32'h0100_0000, top=FF valid, sel=2, 3 ticks.
  - Required: o_sample 01, 02, 03, each valid 2 cycles after its tick.
- Wrap and scale:
  - Stimulus: sawtooth, delta=32'h4000_0000, top=7F.
  - Required: phases 40,80,C0,00 give samples 20, 40, 60, 00.
- Hard sync and rest:
  - Stimulus: after 5 ticks at delta 0x0100_0000, change delta to 0x0200_0000, then to 0.
  - Required: first sample after the change is 02; with sel=1 and delta=0 the sample is 00, not FF.
- Square, pulse and triangle at delta=0x2000_0000, top=FF:
  - Square: 00,00,00,FF,FF,FF,FF,00.
  - Pulse: FF,00,… (h=20 → FF, h=40 → 00).
  - Triangle: h=20 → 40, h=A0 → BF.
  - Triangle check is repeated with the macro undefined, where it must match square.
- Top hold and back-to-back:
  - Stimulus: top_valid=0 with top=00 on consecutive-cycle ticks.
  - Required: previous r_top still applies; valid strobes arrive back-to-back.
  - Stimulus: assert i_rst_n=0 one cycle after a tick.
  - Required: no valid strobe, o_sample=00.

Source files
------------

// File: rtl/channel_wave_generator_if.sv
// Bus between the channel note sequencer and the wave generator.
// master: sequencer side (drives tick, phase delta, top, wave select)
// slave:  wave generator side (returns the scaled PWM compare sample)
interface channel_wave_generator_if;
    logic        i_tick_stb;
    logic [31:0] i_phase_delta;
    logic [7:0]  i_top;
    logic        i_top_valid;
    logic [1:0]  i_wave_sel;
    logic [7:0]  o_sample;
    logic        o_sample_valid;

    modport master (
        output i_tick_stb,
        output i_phase_delta,
        output i_top,
        output i_top_valid,
        output i_wave_sel,
        input  o_sample,
        input  o_sample_valid
    );

    modport slave (
        input  i_tick_stb,
        input  i_phase_delta,
        input  i_top,
        input  i_top_valid,
        input  i_wave_sel,
        output o_sample,
        output o_sample_valid
    );
endinterface

// File: rtl/channel_wave_generator.sv
// channel_wave_generator
// Two-stage pipeline: stage 1 advances a 32-bit phase accumulator on each
// sample tick (with hard sync on delta change and rest on delta 0), stage 2
// maps the phase MSBs to the selected waveform and scales by (top + 1).
// Optional feature macro: CHANNEL_WAVE_TRIANGLE_EN
//   defined   -> wave_sel 3 is triangle
//   undefined -> wave_sel 3 falls back to square
module channel_wave_generator (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    channel_wave_generator_if.slave  bus
);

    logic [31:0] r_phase;
    logic [31:0] r_prev_delta;
    logic [7:0]  r_top;
    logic [1:0]  r_sel;
    logic        r_rest;
    logic        r_s1_valid;

    logic [7:0]  h;
    logic [7:0]  raw;
    logic [8:0]  top_p1;
    logic [7:0]  scaled;

    // Stage 1: phase accumulation and capture of per-tick parameters.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_phase      <= 32'h0;
            r_prev_delta <= 32'h0;
            r_top        <= 8'hFF;
            r_sel        <= 2'd0;
            r_rest       <= 1'b0;
            r_s1_valid   <= 1'b0;
        end else begin
            r_s1_valid <= bus.i_tick_stb;
            if (bus.i_tick_stb) begin
                if (bus.i_phase_delta == 32'h0) begin
                    r_phase <= 32'h0;
                    r_rest  <= 1'b1;
                end else if (bus.i_phase_delta != r_prev_delta) begin
                    // New note: restart from phase 0 and take the first step.
                    r_phase <= bus.i_phase_delta;
                    r_rest  <= 1'b0;
                end else begin
                    r_phase <= r_phase + bus.i_phase_delta;
                    r_rest  <= 1'b0;
                end
                r_prev_delta <= bus.i_phase_delta;
                r_sel        <= bus.i_wave_sel;
                if (bus.i_top_valid) begin
                    r_top <= bus.i_top;
                end
            end
        end
    end

    assign h = r_phase[31:24];

    // Waveform lookup from the phase MSBs; rest forces silence.
    always_comb begin
        raw = 8'h00;
        case (r_sel)
            2'd0: raw = {8{h[7]}};
            2'd1: raw = (h < 8'h40) ? 8'hFF : 8'h00;
            2'd2: raw = h;
`ifdef CHANNEL_WAVE_TRIANGLE_EN
            2'd3: raw = h[7] ? ~{h[6:0], 1'b0} : {h[6:0], 1'b0};
`else
            2'd3: raw = {8{h[7]}};
`endif
        endcase
        if (r_rest) begin
            raw = 8'h00;
        end
    end

    // raw <= 255 and top+1 <= 256, so the product fits 17 bits and bits
    // [15:8] are the exact scaled value.
    assign top_p1 = {1'b0, r_top} + 9'd1;
    assign scaled = 8'((17'(raw) * 17'(top_p1)) >> 8);

    // Stage 2: register the sample and its one-cycle valid strobe.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bus.o_sample       <= 8'h00;
            bus.o_sample_valid <= 1'b0;
        end else begin
            bus.o_sample_valid <= r_s1_valid;
            if (r_s1_valid) begin
                bus.o_sample <= scaled;
            end
        end
    end

endmodule

// File: tb/tb_channel_wave_generator.sv
// Testbench for channel_wave_generator: table of single-tick vectors applied
// in order (expected samples computed by hand), plus hand-written sequences
// for back-to-back ticks, top hold and reset mid-pipeline.
module tb_channel_wave_generator;

    logic i_clk;
    logic i_rst_n;

    channel_wave_generator_if bus ();

    channel_wave_generator dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus.slave)
    );

    typedef struct {
        logic [31:0] delta;
        logic [7:0]  top;
        logic        top_valid;
        logic [1:0]  sel;
        logic [7:0]  exp;
    } vec_t;

    vec_t vq[$];
    int   total = 0;
    int   bad   = 0;

`ifdef CHANNEL_WAVE_TRIANGLE_EN
    localparam logic [7:0] T20 = 8'h40, T40 = 8'h80, T60 = 8'hC0, T80 = 8'hFF, TA0 = 8'hBF;
`else
    localparam logic [7:0] T20 = 8'h00, T40 = 8'h00, T60 = 8'h00, T80 = 8'hFF, TA0 = 8'hFF;
`endif

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic add(input logic [31:0] d, input logic [7:0] t, input logic tv,
                       input logic [1:0] s, input logic [7:0] e);
        vec_t v;
        v.delta = d; v.top = t; v.top_valid = tv; v.sel = s; v.exp = e;
        vq.push_back(v);
    endtask

    task automatic drive(input logic stb, input logic [31:0] d, input logic [7:0] t,
                         input logic tv, input logic [1:0] s);
        bus.i_tick_stb    = stb;
        bus.i_phase_delta = d;
        bus.i_top         = t;
        bus.i_top_valid   = tv;
        bus.i_wave_sel    = s;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 8'h00, 1'b0, 2'd0);
    endtask

    // Single tick, then verify latency of exactly two cycles and a one-cycle strobe.
    task automatic apply_vec(input int idx, input vec_t v);
        string nm;
        nm = $sformatf("vec%0d", idx);
        @(negedge i_clk);
        drive(1'b1, v.delta, v.top, v.top_valid, v.sel);
        @(negedge i_clk);
        idle();
        check1({nm, "_valid_early"}, bus.o_sample_valid, 1'b0);
        @(negedge i_clk);
        check1({nm, "_valid"}, bus.o_sample_valid, 1'b1);
        check8({nm, "_sample"}, bus.o_sample, v.exp);
        @(negedge i_clk);
        check1({nm, "_valid_drop"}, bus.o_sample_valid, 1'b0);
        check8({nm, "_hold"}, bus.o_sample, v.exp);
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_rst_n = 1'b0;
        idle();
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] b2b_exp [4];

        i_rst_n = 1'b0;
        idle();

        // Sawtooth from reset
        add(32'h0100_0000, 8'hFF, 1'b1, 2'd2, 8'h01);
        add(32'h0100_0000, 8'hFF, 1'b1, 2'd2, 8'h02);
        add(32'h0100_0000, 8'hFF, 1'b1, 2'd2, 8'h03);
        // Wrap and scale with top 7F
        add(32'h4000_0000, 8'h7F, 1'b1, 2'd2, 8'h20);
        add(32'h4000_0000, 8'h7F, 1'b1, 2'd2, 8'h40);
        add(32'h4000_0000, 8'h7F, 1'b1, 2'd2, 8'h60);
        add(32'h4000_0000, 8'h7F, 1'b1, 2'd2, 8'h00);
        add(32'h0000_0000, 8'hFF, 1'b1, 2'd2, 8'h00);
        // Five ticks, then hard sync, then rest on pulse
        add(32'h0100_0000, 8'hFF, 1'b1, 2'd2, 8'h01);
        add(32'h0100_0000, 8'hFF, 1'b1, 2'd2, 8'h02);
        add(32'h0100_0000, 8'hFF, 1'b1, 2'd2, 8'h03);
        add(32'h0100_0000, 8'hFF, 1'b1, 2'd2, 8'h04);
        add(32'h0100_0000, 8'hFF, 1'b1, 2'd2, 8'h05);
        add(32'h0200_0000, 8'hFF, 1'b1, 2'd2, 8'h02);
        add(32'h0000_0000, 8'hFF, 1'b1, 2'd1, 8'h00);
        // Square over a full period
        add(32'h2000_0000, 8'hFF, 1'b1, 2'd0, 8'h00);
        add(32'h2000_0000, 8'hFF, 1'b1, 2'd0, 8'h00);
        add(32'h2000_0000, 8'hFF, 1'b1, 2'd0, 8'h00);
        add(32'h2000_0000, 8'hFF, 1'b1, 2'd0, 8'hFF);
        add(32'h2000_0000, 8'hFF, 1'b1, 2'd0, 8'hFF);
        add(32'h2000_0000, 8'hFF, 1'b1, 2'd0, 8'hFF);
        add(32'h2000_0000, 8'hFF, 1'b1, 2'd0, 8'hFF);
        add(32'h2000_0000, 8'hFF, 1'b1, 2'd0, 8'h00);
        add(32'h0000_0000, 8'hFF, 1'b1, 2'd0, 8'h00);
        // Pulse 25%
        add(32'h2000_0000, 8'hFF, 1'b1, 2'd1, 8'hFF);
        add(32'h2000_0000, 8'hFF, 1'b1, 2'd1, 8'h00);
        add(32'h0000_0000, 8'hFF, 1'b1, 2'd1, 8'h00);
        // Triangle (square when the feature is compiled out)
        add(32'h2000_0000, 8'hFF, 1'b1, 2'd3, T20);
        add(32'h2000_0000, 8'hFF, 1'b1, 2'd3, T40);
        add(32'h2000_0000, 8'hFF, 1'b1, 2'd3, T60);
        add(32'h2000_0000, 8'hFF, 1'b1, 2'd3, T80);
        add(32'h2000_0000, 8'hFF, 1'b1, 2'd3, TA0);
        // Top latch / hold
        add(32'h8000_0000, 8'h7F, 1'b1, 2'd0, 8'h7F);
        add(32'hC000_0000, 8'h00, 1'b0, 2'd0, 8'h7F);
        add(32'hC000_0000, 8'h00, 1'b1, 2'd2, 8'h00);
        add(32'hC000_0000, 8'hFF, 1'b1, 2'd2, 8'h40);

        // Reset state
        @(negedge i_clk);
        @(negedge i_clk);
        check8("reset_sample", bus.o_sample, 8'h00);
        check1("reset_valid", bus.o_sample_valid, 1'b0);
        i_rst_n = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            apply_vec(i, vq[i]);
        end

        // Back-to-back ticks; top 7F latched on the first, then top=00 with valid low.
        do_reset();
        b2b_exp[0] = 8'h08; b2b_exp[1] = 8'h10; b2b_exp[2] = 8'h18; b2b_exp[3] = 8'h20;
        for (int k = 0; k < 7; k++) begin
            @(negedge i_clk);
            if (k >= 2 && k <= 5) begin
                check1($sformatf("b2b_valid%0d", k - 2), bus.o_sample_valid, 1'b1);
                check8($sformatf("b2b_sample%0d", k - 2), bus.o_sample, b2b_exp[k-2]);
            end else begin
                check1($sformatf("b2b_novalid%0d", k), bus.o_sample_valid, 1'b0);
            end
            if (k == 0)     drive(1'b1, 32'h1000_0000, 8'h7F, 1'b1, 2'd2);
            else if (k < 4) drive(1'b1, 32'h1000_0000, 8'h00, 1'b0, 2'd2);
            else            idle();
        end

        // Reset asserted one cycle after a tick discards the in-flight sample.
        do_reset();
        @(negedge i_clk);
        drive(1'b1, 32'h8000_0000, 8'hFF, 1'b1, 2'd0);
        @(negedge i_clk);
        idle();
        i_rst_n = 1'b0;
        #1;
        check1("rst_mid_valid_now", bus.o_sample_valid, 1'b0);
        @(negedge i_clk);
        check1("rst_mid_valid", bus.o_sample_valid, 1'b0);
        check8("rst_mid_sample", bus.o_sample, 8'h00);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        check1("rst_mid_after", bus.o_sample_valid, 1'b0);
        check8("rst_mid_after_sample", bus.o_sample, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
